// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte master: FSM states, edge count
// per byte, minimum half-period and the edge-counter width helper.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SPI_EDGES    = 16;
   localparam int SPI_MIN_HALF = 2;

   function automatic int edge_cnt_w(input int edges);
      return $clog2(edges + 1);
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: half-period counter plus edge counter. Strobes lead_stb and
// trail_stb are high in the cycle whose closing clk edge registers that SCLK edge.
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int CLKS_PER_HALF_BIT = 4,
   parameter bit CPOL              = 1'b0,
   localparam int EW               = edge_cnt_w(SPI_EDGES)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   output logic          sclk,
   output logic          lead_stb,
   output logic          trail_stb,
   output logic          last_stb,
   output logic [EW-1:0] edge_cnt
);

   localparam int HW = ($clog2(CLKS_PER_HALF_BIT) < 1) ? 1 : $clog2(CLKS_PER_HALF_BIT);
   localparam logic [HW-1:0] HALF_MAX  = HW'(CLKS_PER_HALF_BIT - 1);
   localparam logic [EW-1:0] EDGE_LAST = EW'(SPI_EDGES);

   logic [HW-1:0] half_q, half_d;
   logic [EW-1:0] edge_q, edge_d;
   logic          sclk_q, sclk_d;
   logic          tick;

   // No further toggles once all 16 edges are out; the FSM leaves XFER next cycle.
   assign tick = run && (half_q == HALF_MAX) && (edge_q != EDGE_LAST);

   always_comb begin
      half_d = half_q;
      edge_d = edge_q;
      sclk_d = sclk_q;
      if (!run) begin
         half_d = '0;
         edge_d = '0;
         sclk_d = CPOL;
      end else begin
         half_d = (half_q == HALF_MAX) ? '0 : half_q + HW'(1);
         if (tick) begin
            edge_d = edge_q + EW'(1);
            sclk_d = ~sclk_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         half_q <= '0;
         edge_q <= '0;
         sclk_q <= CPOL;
      end else begin
         half_q <= half_d;
         edge_q <= edge_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk      = sclk_q;
   assign lead_stb  = tick && !edge_q[0];
   assign trail_stb = tick && edge_q[0];
   assign last_stb  = run && (edge_q == EDGE_LAST);
   assign edge_cnt  = edge_q;

endmodule

// File: rtl/spi_byte_master.sv
// Byte-wide SPI master: IDLE/XFER/DONE FSM with shift and capture registers.
// Define SPI_LSB_FIRST_EN for LSB-first transmit and receive (default MSB first).
module spi_byte_master
   import spi_pkg::*;
#(
   parameter int CLKS_PER_HALF_BIT = 4,
   parameter bit CPOL              = 1'b0,
   parameter bit CPHA              = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_byte,
   input  logic       tx_dv,
   output logic       tx_ready,
   output logic [7:0] rx_byte,
   output logic       rx_dv,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso
);

   localparam int EW = edge_cnt_w(SPI_EDGES);
   localparam logic [EW-1:0] EDGE_PRE_LAST = EW'(SPI_EDGES - 1);

   if (CLKS_PER_HALF_BIT < SPI_MIN_HALF) begin : g_half_chk
      $error("spi_byte_master: CLKS_PER_HALF_BIT must be >= %0d", SPI_MIN_HALF);
   end

`ifdef SPI_LSB_FIRST_EN
   function automatic logic out_bit(input logic [7:0] v);
      return v[0];
   endfunction
   function automatic logic [7:0] shift_out(input logic [7:0] v);
      return v >> 1;
   endfunction
   function automatic logic [7:0] shift_in(input logic [7:0] v, input logic b);
      return {b, v[7:1]};
   endfunction
`else
   function automatic logic out_bit(input logic [7:0] v);
      return v[7];
   endfunction
   function automatic logic [7:0] shift_out(input logic [7:0] v);
      return v << 1;
   endfunction
   function automatic logic [7:0] shift_in(input logic [7:0] v, input logic b);
      return {v[6:0], b};
   endfunction
`endif

   state_t        state_q, state_d;
   logic [7:0]    sh_q, sh_d;
   logic [7:0]    cap_q, cap_d;
   logic [7:0]    rx_byte_q, rx_byte_d;
   logic          mosi_q, mosi_d;
   logic          lead_stb, trail_stb, last_stb;
   logic          shift_stb, sample_stb;
   logic [EW-1:0] edge_cnt;

   spi_clk_gen #(
      .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT),
      .CPOL             (CPOL)
   ) u_clk_gen (
      .clk      (clk),
      .rst      (rst),
      .run      (state_q == XFER),
      .sclk     (sclk),
      .lead_stb (lead_stb),
      .trail_stb(trail_stb),
      .last_stb (last_stb),
      .edge_cnt (edge_cnt)
   );

   // Mode 0 presents bit 0 of the sequence at accept, so trailing edge 16 must not shift.
   assign shift_stb  = CPHA ? lead_stb : (trail_stb && (edge_cnt != EDGE_PRE_LAST));
   assign sample_stb = CPHA ? trail_stb : lead_stb;

   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      cap_d     = cap_q;
      rx_byte_d = rx_byte_q;
      mosi_d    = mosi_q;
      case (state_q)
         IDLE: begin
            if (tx_dv) begin
               state_d = XFER;
               if (CPHA) begin
                  sh_d = tx_byte;
               end else begin
                  mosi_d = out_bit(tx_byte);
                  sh_d   = shift_out(tx_byte);
               end
            end
         end
         XFER: begin
            if (last_stb) begin
               state_d   = DONE;
               mosi_d    = 1'b0;
               rx_byte_d = cap_q;
            end else begin
               if (shift_stb) begin
                  mosi_d = out_bit(sh_q);
                  sh_d   = shift_out(sh_q);
               end
               if (sample_stb) cap_d = shift_in(cap_q, miso);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         sh_q      <= '0;
         cap_q     <= '0;
         rx_byte_q <= '0;
         mosi_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sh_q      <= sh_d;
         cap_q     <= cap_d;
         rx_byte_q <= rx_byte_d;
         mosi_q    <= mosi_d;
      end
   end

   assign tx_ready = (state_q == IDLE);
   assign rx_dv    = (state_q == DONE);
   assign rx_byte  = rx_byte_q;
   assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: mode 0 (H=4, mosi->miso loopback) and
// mode 3 (H=2, byte-returning slave) instances sharing clock and reset.
module tb_spi_byte_master;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_run = 0;
   int   n_fail = 0;

   logic [7:0] tx_byte = 8'h00;
   logic       tx_dv0 = 1'b0, tx_dv3 = 1'b0;
   logic       miso0, miso3 = 1'b0;
   logic       tx_ready0, rx_dv0, sclk0, mosi0;
   logic       tx_ready3, rx_dv3, sclk3, mosi3;
   logic [7:0] rx_byte0, rx_byte3;

   bit         sel = 1'b0;
   logic       sclk_m, mosi_m, txr_m, rxdv_m;
   logic [7:0] rxb_m;

   int         edges, edge_bad, mosi_bad, rxdv_n, rxdv_at, ready_at;
   logic [7:0] mosi_seq, rxb, slv;

   assign miso0  = mosi0;
   assign sclk_m = sel ? sclk3 : sclk0;
   assign mosi_m = sel ? mosi3 : mosi0;
   assign txr_m  = sel ? tx_ready3 : tx_ready0;
   assign rxdv_m = sel ? rx_dv3 : rx_dv0;
   assign rxb_m  = sel ? rx_byte3 : rx_byte0;

   spi_byte_master #(.CLKS_PER_HALF_BIT(4), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
      .clk(clk), .rst(rst), .tx_byte(tx_byte), .tx_dv(tx_dv0), .tx_ready(tx_ready0),
      .rx_byte(rx_byte0), .rx_dv(rx_dv0), .sclk(sclk0), .mosi(mosi0), .miso(miso0));

   spi_byte_master #(.CLKS_PER_HALF_BIT(2), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
      .clk(clk), .rst(rst), .tx_byte(tx_byte), .tx_dv(tx_dv3), .tx_ready(tx_ready3),
      .rx_byte(rx_byte3), .rx_dv(rx_dv3), .sclk(sclk3), .mosi(mosi3), .miso(miso3));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Sequence of bits as seen on the wire, first bit in position 7.
   function automatic logic [7:0] exp_seq(input logic [7:0] b);
      logic [7:0] r;
`ifdef SPI_LSB_FIRST_EN
      for (int i = 0; i < 8; i++) r[7-i] = b[i];
`else
      r = b;
`endif
      return r;
   endfunction

   function automatic logic slave_bit(input logic [7:0] b, input int i);
`ifdef SPI_LSB_FIRST_EN
      return b[i];
`else
      return b[7-i];
`endif
   endfunction

   // One transfer; fixed-length observation window so late activity is visible too.
   task automatic xfer(input bit s, input logic [7:0] b, input int h, input int inject, input int budget);
      int   t0, n;
      logic ps, pm;
      sel = s;
      @(negedge clk);
      tx_byte = b;
      if (s) tx_dv3 = 1'b1; else tx_dv0 = 1'b1;
      @(posedge clk); #1;
      t0 = cyc;
      tx_dv3 = 1'b0; tx_dv0 = 1'b0;
      n_run++; if (txr_m !== 1'b0) begin n_fail++; $display("FAIL accept_ready_low: got %b want 0", txr_m); end
      edges = 0; edge_bad = 0; mosi_bad = 0; rxdv_n = 0; rxdv_at = -1; ready_at = -1;
      mosi_seq = 8'h00; rxb = 8'h00;
      ps = sclk_m; pm = mosi_m;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk); #1;
         n = cyc - t0;
         if (inject > 0 && n == inject) begin tx_byte = 8'hFF; tx_dv0 = 1'b1; end
         else if (inject > 0 && n == inject + 1) tx_dv0 = 1'b0;
         if (sclk_m !== ps) begin
            edges++;
            if (n != edges * h) edge_bad++;
            if (edges % 2 == 1) begin
               mosi_seq = {mosi_seq[6:0], mosi_m};
               if (s) miso3 = slave_bit(slv, (edges - 1) / 2);
            end
         end
         if (s && (mosi_m !== pm) && edges < 16 && !((sclk_m !== ps) && sclk_m == 1'b0)) mosi_bad++;
         if (rxdv_m === 1'b1) begin rxdv_n++; rxdv_at = n; rxb = rxb_m; end
         if (txr_m === 1'b1 && ready_at < 0) ready_at = n;
         ps = sclk_m; pm = mosi_m;
      end
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk);
      n_run++; if (tx_ready0 !== 1'b1) begin n_fail++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready0); end
      n_run++; if (rx_dv0 !== 1'b0) begin n_fail++; $display("FAIL rst_rx_dv: got %b want 0", rx_dv0); end
      n_run++; if (rx_byte0 !== 8'h00) begin n_fail++; $display("FAIL rst_rx_byte: got %h want 00", rx_byte0); end
      n_run++; if (sclk0 !== 1'b0) begin n_fail++; $display("FAIL rst_sclk_cpol0: got %b want 0", sclk0); end
      n_run++; if (sclk3 !== 1'b1) begin n_fail++; $display("FAIL rst_sclk_cpol1: got %b want 1", sclk3); end
      n_run++; if (mosi0 !== 1'b0) begin n_fail++; $display("FAIL rst_mosi: got %b want 0", mosi0); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_mode0();
      xfer(1'b0, 8'hA5, 4, 0, 110);
      n_run++; if (edges != 16) begin n_fail++; $display("FAIL m0_edges: got %0d want 16", edges); end
      n_run++; if (edge_bad != 0) begin n_fail++; $display("FAIL m0_edge_timing: got %0d bad want 0", edge_bad); end
      n_run++; if (mosi_seq !== exp_seq(8'hA5)) begin n_fail++; $display("FAIL m0_mosi_seq: got %b want %b", mosi_seq, exp_seq(8'hA5)); end
      n_run++; if (rxb !== 8'hA5) begin n_fail++; $display("FAIL m0_rx_byte: got %h want a5", rxb); end
      n_run++; if (rxdv_at != 65) begin n_fail++; $display("FAIL m0_rx_dv_time: got T+%0d want T+65", rxdv_at); end
      n_run++; if (rxdv_n != 1) begin n_fail++; $display("FAIL m0_rx_dv_count: got %0d want 1", rxdv_n); end
      n_run++; if (ready_at != 66) begin n_fail++; $display("FAIL m0_ready_time: got T+%0d want T+66", ready_at); end
      n_run++; if (mosi0 !== 1'b0 || sclk0 !== 1'b0) begin n_fail++; $display("FAIL m0_idle_lines: got mosi %b sclk %b want 0 0", mosi0, sclk0); end
   endtask

   task automatic test_mode3();
      slv = 8'h3C;
      xfer(1'b1, 8'hA5, 2, 0, 60);
      n_run++; if (edges != 16) begin n_fail++; $display("FAIL m3_edges: got %0d want 16", edges); end
      n_run++; if (edge_bad != 0) begin n_fail++; $display("FAIL m3_edge_timing: got %0d bad want 0", edge_bad); end
      n_run++; if (rxb !== 8'h3C) begin n_fail++; $display("FAIL m3_rx_byte: got %h want 3c", rxb); end
      n_run++; if (rxdv_at != 33) begin n_fail++; $display("FAIL m3_rx_dv_time: got T+%0d want T+33", rxdv_at); end
      n_run++; if (mosi_bad != 0) begin n_fail++; $display("FAIL m3_mosi_on_fall: got %0d stray changes want 0", mosi_bad); end
      n_run++; if (mosi_seq !== exp_seq(8'hA5)) begin n_fail++; $display("FAIL m3_mosi_seq: got %b want %b", mosi_seq, exp_seq(8'hA5)); end
      n_run++; if (sclk3 !== 1'b1) begin n_fail++; $display("FAIL m3_sclk_idle: got %b want 1", sclk3); end
   endtask

   task automatic test_busy();
      xfer(1'b0, 8'h12, 4, 10, 130);
      n_run++; if (mosi_seq !== exp_seq(8'h12)) begin n_fail++; $display("FAIL busy_mosi_seq: got %b want %b", mosi_seq, exp_seq(8'h12)); end
      n_run++; if (rxb !== 8'h12) begin n_fail++; $display("FAIL busy_rx_byte: got %h want 12", rxb); end
      n_run++; if (rxdv_n != 1) begin n_fail++; $display("FAIL busy_rx_dv_count: got %0d want 1", rxdv_n); end
      n_run++; if (edges != 16) begin n_fail++; $display("FAIL busy_edges: got %0d want 16", edges); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bb [3];
      logic [7:0] got [3];
      int   idx, nedge, nrx, acc_bad;
      logic ps, pr, pending;
      bb[0] = 8'h81; bb[1] = 8'h23; bb[2] = 8'h45;
      got[0] = 8'h00; got[1] = 8'h00; got[2] = 8'h00;
      idx = 0; nedge = 0; nrx = 0; acc_bad = 0; pr = 1'b1;
      sel = 1'b0;
      @(negedge clk);
      tx_byte = bb[0]; tx_dv0 = 1'b1; pending = 1'b1; ps = sclk0;
      for (int i = 0; i < 260; i++) begin
         @(posedge clk); #1;
         if (pending) begin
            pending = 1'b0; tx_dv0 = 1'b0; idx++;
            if (tx_ready0 !== 1'b0) acc_bad++;
         end
         if (sclk0 !== ps) nedge++;
         if (rx_dv0 === 1'b1) begin if (nrx < 3) got[nrx] = rx_byte0; nrx++; end
         if (tx_ready0 === 1'b1 && pr === 1'b0 && idx < 3) begin
            tx_byte = bb[idx]; tx_dv0 = 1'b1; pending = 1'b1;
         end
         ps = sclk0; pr = tx_ready0;
      end
      n_run++; if (nedge != 48) begin n_fail++; $display("FAIL b2b_edges: got %0d want 48", nedge); end
      n_run++; if (nrx != 3) begin n_fail++; $display("FAIL b2b_rx_dv_count: got %0d want 3", nrx); end
      n_run++; if (acc_bad != 0) begin n_fail++; $display("FAIL b2b_accept: got %0d missed want 0", acc_bad); end
      for (int k = 0; k < 3; k++) begin
         n_run++; if (got[k] !== bb[k]) begin n_fail++; $display("FAIL b2b_rx_byte%0d: got %h want %h", k, got[k], bb[k]); end
      end
   endtask

   task automatic test_bit_order();
      logic first;
`ifdef SPI_LSB_FIRST_EN
      first = 1'b1;
`else
      first = 1'b0;
`endif
      xfer(1'b0, 8'h01, 4, 0, 80);
      n_run++; if (mosi_seq[7] !== first) begin n_fail++; $display("FAIL order_first_bit: got %b want %b", mosi_seq[7], first); end
      n_run++; if (mosi_seq !== exp_seq(8'h01)) begin n_fail++; $display("FAIL order_mosi_seq: got %b want %b", mosi_seq, exp_seq(8'h01)); end
      n_run++; if (rxb !== 8'h01) begin n_fail++; $display("FAIL order_rx_byte: got %h want 01", rxb); end
   endtask

   task automatic test_reset_mid();
      int   e, nrx, nsc;
      logic ps;
      sel = 1'b0; e = 0;
      @(negedge clk);
      tx_byte = 8'h55; tx_dv0 = 1'b1;
      @(posedge clk); #1;
      tx_dv0 = 1'b0; ps = sclk0;
      for (int i = 0; i < 60 && e < 7; i++) begin
         @(posedge clk); #1;
         if (sclk0 !== ps) e++;
         ps = sclk0;
      end
      n_run++; if (e != 7) begin n_fail++; $display("FAIL rmid_reach_edge7: got %0d edges want 7", e); end
      rst = 1'b1;
      #1;
      n_run++; if (sclk0 !== 1'b0) begin n_fail++; $display("FAIL rmid_sclk: got %b want 0", sclk0); end
      n_run++; if (tx_ready0 !== 1'b1) begin n_fail++; $display("FAIL rmid_tx_ready: got %b want 1", tx_ready0); end
      n_run++; if (mosi0 !== 1'b0) begin n_fail++; $display("FAIL rmid_mosi: got %b want 0", mosi0); end
      @(negedge clk);
      rst = 1'b0;
      nrx = 0; nsc = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (rx_dv0 === 1'b1) nrx++;
         if (sclk0 !== 1'b0) nsc++;
      end
      n_run++; if (nrx != 0) begin n_fail++; $display("FAIL rmid_no_rx_dv: got %0d pulses want 0", nrx); end
      n_run++; if (nsc != 0) begin n_fail++; $display("FAIL rmid_sclk_quiet: got %0d active cycles want 0", nsc); end
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_mode3();
      test_busy();
      test_back_to_back();
      test_bit_order();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
